// File: rtl/rsnn_pkg.sv
// Shared constants and FSM state type for the RSNN weight-memory feeder.
package rsnn_pkg;

  localparam int FRAME_BITS  = 312;
  localparam int BYTE_W      = 8;
  localparam int CNT_W       = 9;
  localparam int FRAME_BYTES = FRAME_BITS / BYTE_W;
  localparam int BIT_W       = $clog2(BYTE_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    CHECK = 2'd3
  } fsm_state_e;

  function automatic logic frame_full(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_W'(FRAME_BITS));
  endfunction

endpackage

// File: rtl/fipo_byte_serializer_if.sv
// Byte-strobe input bus plus the serial link to the SIPO weight memory.
interface fipo_byte_serializer_if;
  import rsnn_pkg::*;

  logic [BYTE_W-1:0] byte_in;
  logic              byte_strobe;
  logic              ready;
  logic              serial_out;
  logic              mem_enable;
  logic              mem_data_written;
  logic              mem_end_writing;

  modport master (
    output byte_in, byte_strobe, mem_data_written, mem_end_writing,
    input  ready, serial_out, mem_enable
  );

  modport slave (
    input  byte_in, byte_strobe, mem_data_written, mem_end_writing,
    output ready, serial_out, mem_enable
  );

endinterface

// File: rtl/fipo_ack_checker.sv
// Compares memory acknowledges against what the serializer drove one cycle earlier;
// emits single-cycle error/confirm pulses for the top to register.
module fipo_ack_checker
  import rsnn_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic shift_active,
  input  logic check_active,
  input  logic mem_data_written,
  input  logic mem_end_writing,
  output logic ack_err,
  output logic end_ok,
  output logic end_err
);

  logic en_d_r;

  // Delayed copy of "a frame bit was written", which is when data_written is due.
  always_ff @(posedge clk) begin
    if (!rst) begin
      en_d_r <= 1'b0;
    end else begin
      en_d_r <= shift_active;
    end
  end

  // data_written must track en_d_r exactly: missing or unexpected is an error.
  always_comb begin
    ack_err = en_d_r ? ~mem_data_written : mem_data_written;
    end_ok  = check_active & mem_end_writing;
    end_err = check_active & ~mem_end_writing;
  end

endmodule

// File: rtl/fipo_byte_serializer.sv
// Serializes strobed bytes LSB-first into the 312-bit SIPO weight memory,
// adds the rewind enable cycle and watches the memory's acknowledges.
module fipo_byte_serializer
  import rsnn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fipo_byte_serializer_if.slave bus,
  output logic                 frame_done,
  output logic                 overrun,
  output logic                 link_error,
  output logic [CNT_W-1:0]     bits_sent
);

  fsm_state_e        state_r, state_s;
  logic [BYTE_W-1:0] shift_r, shift_s;
  logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_s;
  logic [CNT_W-1:0]  bits_sent_r, bits_sent_s;
  logic              ready_r, serial_out_r, mem_enable_r;
  logic              frame_done_r, overrun_r, link_error_r;
  logic              ack_err_s, end_ok_s, end_err_s;

  fipo_ack_checker u_ack (
    .clk              (clk),
    .rst              (rst),
    .shift_active     (state_r == SHIFT),
    .check_active     (state_r == CHECK),
    .mem_data_written (bus.mem_data_written),
    .mem_end_writing  (bus.mem_end_writing),
    .ack_err          (ack_err_s),
    .end_ok           (end_ok_s),
    .end_err          (end_err_s)
  );

  // Next-state, shifter and counter update.
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    bit_cnt_s   = bit_cnt_r;
    bits_sent_s = bits_sent_r;
    case (state_r)
      IDLE: begin
        if (bus.byte_strobe && ready_r) begin
          state_s   = SHIFT;
          shift_s   = bus.byte_in;
          bit_cnt_s = {BIT_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        shift_s     = shift_r >> 1;
        bit_cnt_s   = bit_cnt_r + BIT_W'(1);
        bits_sent_s = bits_sent_r + CNT_W'(1);
        if (bit_cnt_r == BIT_W'(BYTE_W - 1)) begin
          state_s = frame_full(bits_sent_s) ? FLUSH : IDLE;
        end else begin
          state_s = SHIFT;
        end
      end
      FLUSH: begin
        state_s = CHECK;
      end
      CHECK: begin
        state_s     = IDLE;
        bits_sent_s = {CNT_W{1'b0}};
      end
      default: begin
        state_s     = IDLE;
        shift_s     = {BYTE_W{1'b0}};
        bit_cnt_s   = {BIT_W{1'b0}};
        bits_sent_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and registered outputs; outputs are derived from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      shift_r      <= {BYTE_W{1'b0}};
      bit_cnt_r    <= {BIT_W{1'b0}};
      bits_sent_r  <= {CNT_W{1'b0}};
      ready_r      <= 1'b1;
      serial_out_r <= 1'b0;
      mem_enable_r <= 1'b0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
      link_error_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      shift_r      <= shift_s;
      bit_cnt_r    <= bit_cnt_s;
      bits_sent_r  <= bits_sent_s;
      ready_r      <= (state_s == IDLE);
      serial_out_r <= (state_s == SHIFT) ? shift_s[0] : 1'b0;
      mem_enable_r <= (state_s == SHIFT) || (state_s == FLUSH);
      frame_done_r <= end_ok_s;
      overrun_r    <= overrun_r | (bus.byte_strobe & ~ready_r);
      link_error_r <= link_error_r | ack_err_s | end_err_s;
    end
  end

  assign bus.ready      = ready_r;
  assign bus.serial_out = serial_out_r;
  assign bus.mem_enable = mem_enable_r;
  assign frame_done     = frame_done_r;
  assign overrun        = overrun_r;
  assign link_error     = link_error_r;
  assign bits_sent      = bits_sent_r;

endmodule

// File: tb/tb_fipo_byte_serializer.sv
// Scoreboard bench: driver queues expected serial bits, a negedge monitor checks them,
// and a behavioural SIPO memory model supplies acknowledges and captures frames.
module tb_fipo_byte_serializer;
  import rsnn_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_done, overrun, link_error;
  logic [CNT_W-1:0] bits_sent;

  fipo_byte_serializer_if bus();

  fipo_byte_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .frame_done (frame_done),
    .overrun    (overrun),
    .link_error (link_error),
    .bits_sent  (bits_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int exp_frames = 0;
  int frame_bits = 0;
  logic exp_q[$];
  logic exp_bit;
  logic mon_en = 1'b0;

  // memory model state and fault knobs
  logic [FRAME_BITS-1:0] mem_par;
  int   mem_cnt;
  logic dw, ew;
  logic no_end = 1'b0;
  logic drop_arm = 1'b0;
  int   drop_idx = 0;
  logic [7:0] frame_bytes [FRAME_BYTES];

  assign bus.mem_data_written = dw;
  assign bus.mem_end_writing  = ew;

  always @(posedge clk) begin
    if (!rst) begin
      mem_cnt <= 0;
      dw      <= 1'b0;
      ew      <= 1'b0;
      mem_par <= '0;
    end else if (bus.mem_enable) begin
      if (mem_cnt < FRAME_BITS) begin
        mem_par[mem_cnt] <= bus.serial_out;
        mem_cnt <= mem_cnt + 1;
        dw <= !(drop_arm && mem_cnt == drop_idx);
        ew <= 1'b0;
      end else begin
        mem_cnt <= 0;
        dw <= 1'b0;
        ew <= !no_end;
      end
    end else begin
      dw <= 1'b0;
      ew <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst && mon_en && bus.mem_enable) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL serial_unexpected actual=enable_high required=no_enable t=%0t", $time);
      end else begin
        exp_bit = exp_q.pop_front();
        if (bus.serial_out !== exp_bit) begin
          errors++;
          $display("FAIL serial_bit actual=%0b required=%0b t=%0t", bus.serial_out, exp_bit, $time);
        end
      end
    end
    if (rst && frame_done === 1'b1) fd_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    exp_q.delete();
    frame_bits = 0;
    mon_en = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!bus.ready && n < 50) begin
      step();
      n++;
    end
    if (!bus.ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1 t=%0t", $time);
    end else begin
      bus.byte_in = b;
      bus.byte_strobe = 1'b1;
      step();
      bus.byte_strobe = 1'b0;
      for (int k = 0; k < 8; k++) exp_q.push_back(b[k]);
      frame_bits += 8;
      if (frame_bits == FRAME_BITS) begin
        exp_q.push_back(1'b0);
        frame_bits = 0;
        if (!no_end) exp_frames++;
      end
    end
  endtask

  task automatic check_frame(input string name);
    for (int i = 0; i < FRAME_BYTES; i++)
      check(name, {24'd0, mem_par[8*i +: 8]}, {24'd0, frame_bytes[i]});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.byte_in = 8'h00;
    bus.byte_strobe = 1'b0;
    do_reset();
    check("rst_ready", bus.ready, 1);
    check("rst_enable", bus.mem_enable, 0);
    check("rst_serial", bus.serial_out, 0);
    check("rst_bits", bits_sent, 0);
    check("rst_flags", {frame_done, overrun, link_error}, 0);

    // single byte 0xA5
    send_byte(8'hA5);
    check("a5_enable_t1", bus.mem_enable, 1);
    check("a5_ready_t1", bus.ready, 0);
    repeat (8) step();
    check("a5_ready_t9", bus.ready, 1);
    check("a5_enable_t9", bus.mem_enable, 0);
    check("a5_bits", bits_sent, 8);
    check("a5_link", link_error, 0);

    // overrun: second strobe 3 cycles into the byte is dropped
    send_byte(8'h3C);
    repeat (3) step();
    bus.byte_in = 8'hFF;
    bus.byte_strobe = 1'b1;
    step();
    bus.byte_strobe = 1'b0;
    repeat (10) step();
    check("ovr_flag", overrun, 1);
    check("ovr_bits", bits_sent, frame_bits);
    check("ovr_queue", exp_q.size(), 0);

    // reset in the middle of a byte
    send_byte(8'h5A);
    repeat (2) step();
    do_reset();
    check("mid_rst_ready", bus.ready, 1);
    check("mid_rst_enable", bus.mem_enable, 0);
    check("mid_rst_bits", bits_sent, 0);
    check("mid_rst_flags", {frame_done, overrun, link_error}, 0);

    // full frame of bytes 0x00..0x26
    for (int i = 0; i < FRAME_BYTES; i++) begin
      frame_bytes[i] = 8'(i);
      send_byte(frame_bytes[i]);
    end
    repeat (20) step();
    check("frame1_done_cnt", fd_cnt, 1);
    check("frame1_low_byte", {24'd0, mem_par[7:0]}, 32'h00);
    check("frame1_high_byte", {24'd0, mem_par[311:304]}, 32'h26);
    check_frame("frame1_byte");
    check("frame1_bits", bits_sent, 0);
    check("frame1_link", link_error, 0);
    check("frame1_queue", exp_q.size(), 0);

    // random frame with random idle gaps
    for (int i = 0; i < FRAME_BYTES; i++) begin
      frame_bytes[i] = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) step();
      send_byte(frame_bytes[i]);
    end
    repeat (20) step();
    check("frame2_done_cnt", fd_cnt, exp_frames);
    check_frame("frame2_byte");
    check("frame2_link", link_error, 0);
    check("frame2_overrun", overrun, 0);

    // missing acknowledge after bit 5
    drop_idx = frame_bits + 5;
    drop_arm = 1'b1;
    send_byte(8'($urandom_range(0, 255)));
    repeat (6) step();
    check("drop_link_before", link_error, 0);
    step();
    check("drop_link_after", link_error, 1);
    drop_arm = 1'b0;
    repeat (20) step();
    check("drop_link_sticky", link_error, 1);

    // end_writing never arrives
    do_reset();
    no_end = 1'b1;
    for (int i = 0; i < FRAME_BYTES; i++) send_byte(8'($urandom_range(0, 255)));
    repeat (20) step();
    check("noend_link", link_error, 1);
    check("noend_done_cnt", fd_cnt, exp_frames);
    check("noend_bits", bits_sent, 0);
    check("noend_ready", bus.ready, 1);
    no_end = 1'b0;
    check("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
